// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding data-memory access with alignment checks, lane steering and load extension
module load_store_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        ld_signed,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        addr_err,
  output logic        bus_err,
  output logic        dm_req,
  output logic        dm_we,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic rd, sgn;
  logic [1:0] sz, off;
  logic op_ok, bad, timeout;
  logic [3:0] be_n;
  logic [31:0] wd_n, ext;
  logic [7:0] byte_v;
  logic [15:0] half_v;
  // request decode, lane steering, load extension and next state
  always_comb begin
    op_ok = req_valid && (mem_read ^ mem_write);
    bad = size == 2'b11 || (size == 2'b01 && addr[0]) || (size == 2'b00 && addr[1:0] != 2'b00);
    timeout = !dm_ack && cnt == CNT_W'(TIMEOUT - 1);
    be_n = size == 2'b00 ? 4'b1111 : size == 2'b01 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b0001 << addr[1:0];
    wd_n = size == 2'b00 ? wdata : size == 2'b01 ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
    byte_v = dm_rdata[8*off +: 8];
    half_v = dm_rdata[16*off[1] +: 16];
    ext = sz == 2'b00 ? dm_rdata : sz == 2'b01 ? {{16{sgn & half_v[15]}}, half_v} : {{24{sgn & byte_v[7]}}, byte_v};
    state_n = state;
    state_n = state == IDLE ? (op_ok && !bad ? ACCESS : IDLE) :
              state == ACCESS ? (dm_ack ? RESP : timeout ? IDLE : ACCESS) : IDLE;
  end
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  // registered outputs, latched request fields and timeout counter
  always_ff @(posedge clk) begin
    if (rst) begin
      stall <= 1'b0;
      done <= 1'b0;
      rdata <= '0;
      addr_err <= 1'b0;
      bus_err <= 1'b0;
      dm_req <= 1'b0;
      dm_we <= 1'b0;
      dm_be <= '0;
      dm_addr <= '0;
      dm_wdata <= '0;
      cnt <= '0;
      rd <= 1'b0;
      sgn <= 1'b0;
      sz <= '0;
      off <= '0;
    end else begin
      done <= 1'b0;
      addr_err <= 1'b0;
      bus_err <= 1'b0;
      case (state)
        IDLE: if (op_ok) begin
          if (bad) addr_err <= 1'b1;
          else begin
            dm_req <= 1'b1;
            stall <= 1'b1;
            cnt <= '0;
            dm_we <= mem_write;
            dm_be <= be_n;
            dm_addr <= {addr[31:2], 2'b00};
            dm_wdata <= wd_n;
            rd <= mem_read;
            sgn <= ld_signed;
            sz <= size;
            off <= addr[1:0];
          end
        end
        ACCESS: if (dm_ack) begin
          dm_req <= 1'b0;
          if (rd) rdata <= ext;
        end else if (timeout) begin
          dm_req <= 1'b0;
          bus_err <= 1'b1;
          stall <= 1'b0;
        end else cnt <= cnt + 1'b1;
        RESP: begin
          done <= 1'b1;
          stall <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule
